// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer
//   Performs a W = CHUNK*CHUNKS bit addition on an external, purely
//   combinational CHUNK-bit adder. The sequencer feeds one operand chunk per
//   cycle, starting with the LSB chunk. It chains the carry between chunks
//   through a register.
//
//   Optional build macro: WIDE_ADD_SEQUENCER_SUB_EN
//     Adds the op_sub input. op_sub=1 computes A-B modulo 2^W. In that case
//     c_out=1 means no borrow occurred. Timing is the same in both builds.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   request handshake (accepted only in IDLE)
//   op_a, op_b, op_cin  operands and carry into chunk 0
//   op_sub              (optional) subtract select, latched at accept
//   add_a/add_b/add_cin drive the external adder (zero outside RUN)
//   add_s/add_cout      external adder result
//   out_valid/out_ready result handshake
//   sum, c_out          W-bit result and carry out of the top chunk
//   busy                high while an operation is in RUN or DONE
module wide_add_sequencer #(
  parameter int CHUNK  = 4,
  parameter int CHUNKS = 4,
  localparam int W     = CHUNK * CHUNKS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  input  logic             op_cin,
`ifdef WIDE_ADD_SEQUENCER_SUB_EN
  input  logic             op_sub,
`endif
  output logic [CHUNK-1:0] add_a,
  output logic [CHUNK-1:0] add_b,
  output logic             add_cin,
  input  logic [CHUNK-1:0] add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     sum,
  output logic             c_out,
  output logic             busy
);

  localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     op_a_r, op_b_r;
  logic [W-1:0]     sum_r, sum_nxt;
  logic             c_out_r;
  logic             sub_r;
  logic             sub_in;

`ifdef WIDE_ADD_SEQUENCER_SUB_EN
  assign sub_in = op_sub;
`else
  assign sub_in = 1'b0;
  assign sub_r  = 1'b0;
`endif

  // Reset gates in_ready combinationally, so a request presented during reset is never seen.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_r;
  assign c_out     = c_out_r;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Chunk select for the adder and write-back of the current chunk's result.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    sum_nxt = sum_r;
    if (state == RUN) begin
      add_cin = carry;
      for (int i = 0; i < CHUNKS; i++) begin
        if (idx == IDX_W'(i)) begin
          add_a = op_a_r[i*CHUNK +: CHUNK];
          // Subtraction is A + ~B + 1, with the +1 supplied by the initial carry.
          add_b = sub_r ? ~op_b_r[i*CHUNK +: CHUNK] : op_b_r[i*CHUNK +: CHUNK];
          sum_nxt[i*CHUNK +: CHUNK] = add_s;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      op_a_r  <= '0;
      op_b_r  <= '0;
      sum_r   <= '0;
      c_out_r <= 1'b0;
`ifdef WIDE_ADD_SEQUENCER_SUB_EN
      sub_r   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a_r <= op_a;
            op_b_r <= op_b;
            carry  <= sub_in ? 1'b1 : op_cin;
            idx    <= '0;
            sum_r  <= '0;
`ifdef WIDE_ADD_SEQUENCER_SUB_EN
            sub_r  <= op_sub;
`endif
          end
        end
        RUN: begin
          sum_r <= sum_nxt;
          carry <= add_cout;
          if (idx == LAST) begin
            c_out_r <= add_cout;
            idx     <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
module tb_wide_add_sequencer;

  localparam int CHUNK  = 4;
  localparam int CHUNKS = 4;
  localparam int W      = CHUNK * CHUNKS;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     op_a, op_b;
  logic             op_cin;
  logic             op_sub;
  logic [CHUNK-1:0] add_a, add_b, add_s;
  logic             add_cin, add_cout;
  logic             out_valid, out_ready;
  logic [W-1:0]     sum;
  logic             c_out, busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W:0] sb_q[$];

  always #5 clk = ~clk;

  // External narrow ripple adder
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{CHUNK{1'b0}}, add_cin};

  wide_add_sequencer #(.CHUNK(CHUNK), .CHUNKS(CHUNKS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
`ifdef WIDE_ADD_SEQUENCER_SUB_EN
    .op_sub(op_sub),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept one request, step through RUN checking chunk order and carries,
  // optionally stall in DONE for 'hold' cycles, then pop and check the result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input int hold);
    logic [W-1:0] bb;
    logic         c0;
    logic [W:0]   res;
    logic [W:0]   part;
    logic [W-1:0] msk;
    int           n;
    bb = sub ? ~b : b;
    c0 = sub ? 1'b1 : cin;
    op_a = a; op_b = b; op_cin = cin; op_sub = sub; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin tick; n++; end
    check("in_ready_before_accept", in_ready, 1);
    @(posedge clk);
    sb_q.push_back({1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0});
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < CHUNKS; i++) begin
      msk  = (i == 0) ? '0 : ((W'(1) << (i * CHUNK)) - W'(1));
      part = ({1'b0, a & msk} + {1'b0, bb & msk} + {{W{1'b0}}, c0}) >> (i * CHUNK);
      check($sformatf("add_a[%0d]", i), add_a, a[i*CHUNK +: CHUNK]);
      check($sformatf("add_b[%0d]", i), add_b, bb[i*CHUNK +: CHUNK]);
      check($sformatf("add_cin[%0d]", i), add_cin, part[0]);
      check($sformatf("run_out_valid[%0d]", i), out_valid, 0);
      check($sformatf("run_in_ready[%0d]", i), in_ready, 0);
      check($sformatf("run_busy[%0d]", i), busy, 1);
      tick;
    end
    check("out_valid_latency", out_valid, 1);
    res = sb_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      op_a = W'($urandom);
      tick;
      check("hold_out_valid", out_valid, 1);
      check("hold_sum", sum, res[W-1:0]);
      check("hold_c_out", c_out, res[W]);
      check("hold_in_ready", in_ready, 0);
    end
    check("sum", sum, res[W-1:0]);
    check("c_out", c_out, res[W]);
    check("done_add_a_zero", add_a, 0);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_cin = 1'b0; op_sub = 1'b0;
    tick; tick;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_c_out", c_out, 0);
    check("rst_add_a", add_a, 0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready, 1);

    // Abort mid-RUN
    op_a = 16'h1234; op_b = 16'h4321; op_cin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check("abort_busy_run", busy, 1);
    tick; tick;
    check("abort_add_a_idx2", add_a, 4'h2);
    rst = 1'b1;
    tick;
    check("abort_busy", busy, 0);
    check("abort_add_a", add_a, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready_in_rst", in_ready, 0);
    rst = 1'b0;
    #1;
    check("abort_in_ready_after", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (out_valid) seen++;
    end
    check("abort_no_out_valid", seen, 0);

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
    // Backpressure: stalled in DONE with a new request waiting
    run_op(16'hA5C3, 16'h3C5A, 1'b1, 1'b0, 5);
    run_op(16'h8001, 16'h7FFF, 1'b0, 1'b0, 0);
`ifdef WIDE_ADD_SEQUENCER_SUB_EN
    run_op(16'h1000, 16'h0001, 1'b0, 1'b1, 0);
    run_op(16'h0000, 16'h0001, 1'b0, 1'b1, 0);
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
`endif
    for (int k = 0; k < 4; k++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle controller that performs a wide (CHUNK*CHUNKS-bit) addition on the team's narrow CHUNK-bit ripple-carry adder.
- Feeds one operand chunk per cycle, LSB chunk first, and chains the carry through a register.
- Sits between a valid/ready requester and the external adder instance; the adder itself stays purely combinational.

Parameters:
- CHUNK, 4, width of the external adder (a, b, s).
- CHUNKS, 4, number of chunks per operation (>=1); W = CHUNK*CHUNKS = 16 by default.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready at posedge.
- op_a  in  W  operand A.
- op_b  in  W  operand B.
- op_cin  in  1  carry into chunk 0.
- add_a  out  CHUNK  to adder a.
- add_b  out  CHUNK  to adder b.
- add_cin  out  1  to adder c_in.
- add_s  in  CHUNK  from adder s.
- add_cout  in  1  from adder c_out.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready at posedge.
- sum  out  W  result.
- c_out  out  1  carry out of the top chunk.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. All state changes on the rising edge of `clk`.
- Reset: state=IDLE, idx=0, carry reg=0, operand regs=0, sum=0, c_out=0, out_valid=0, busy=0.
  - in_ready=0 in any cycle where rst=1; it is 1 in the first cycle after rst deasserts.
  - Reset in RUN or DONE aborts the operation and discards the result. No partial out_valid is produced.
- FSM:
  - IDLE: in_ready=1.
    - On handshake: latch op_a, op_b; carry<=op_cin; idx<=0; clear sum; go to RUN.
    - in_valid without in_ready is never sampled.
  - RUN: in_ready=0.
    - add_a = opA_reg[idx*CHUNK +: CHUNK]; add_b = opB_reg chunk idx; add_cin = carry reg (all combinational from registers).
    - Each posedge: sum[idx chunk] <= add_s; carry <= add_cout; idx <= idx+1.
    - At idx==CHUNKS-1: c_out <= add_cout and go to DONE.
  - DONE: out_valid=1; sum and c_out held stable; in_ready=0.
    - On out_ready=1: out_valid<=0, go to IDLE.
    - No back-to-back accept: one IDLE cycle minimum between operations.
- Outside RUN: add_a, add_b and add_cin are driven to 0.
- Latency: if the request handshake occurs at posedge t, out_valid is 1 after posedge t+CHUNKS. With CHUNKS=1: one RUN cycle, then DONE.
- Arithmetic: unsigned modulo 2^W; the carry propagates between chunks only through the carry register.
- idx is a counter of width clog2(CHUNKS) (min 1 bit); it never exceeds CHUNKS-1.
- Simultaneous events: rst takes priority over any handshake. Input signals are ignored outside IDLE.

Optional Feature:
- Macro: WIDE_ADD_SEQUENCER_SUB_EN.
- Defined: adds input port op_sub (1 bit), latched at accept. When op_sub=1:
  - add_b drives the inverted opB chunk.
  - The initial carry is forced to 1 (op_cin ignored).
  - Result is A-B modulo 2^W; c_out=1 means no borrow.
  - op_sub=0 behaves exactly as add.
- Not defined: port absent; add only. Timing is identical in both builds.

Test Plan:
- Reset and abort: rst=1 for 2 cycles, release; accept a request, then assert rst mid-RUN (idx=2) -> out_valid never rises, busy=0 and add_a=0 after that edge, in_ready=1 on the cycle after rst drops.
- Add and chunk ordering: 0x1234+0x4321, cin=0 -> add_a sequence 4,3,2,1 on consecutive RUN cycles; sum=0x5555, c_out=0; out_valid asserted exactly 4 edges after accept.
- Full carry chain: 0xFFFF+0x0001, cin=0 -> sum=0x0000, c_out=1; internal carry=1 after every chunk.
- Carry-in and zero operands: 0x0000+0x0000, cin=1 -> sum=0x0001, c_out=0. Then 0xFFFF+0xFFFF, cin=1 -> sum=0xFFFF, c_out=1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and changing op_a -> sum/c_out/out_valid stable, in_ready=0. Raise out_ready -> IDLE next cycle, new request accepted one cycle later.
- With WIDE_ADD_SEQUENCER_SUB_EN: 0x1000-0x0001 -> sum=0x0FFF, c_out=1; 0x0000-0x0001 -> sum=0xFFFF, c_out=0; op_sub=0 repeats the add scenario above unchanged.
